// File: rtl/hex7_pkg.sv
// Shared constants and anode helpers for the hex7 display scanner.
// Anode vectors are built at MAX_DIGITS width and sized down by the user.
package hex7_pkg;

  localparam int MAX_DIGITS = 16;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // All anodes of a display with 'digits' digits switched off (active-low).
  function automatic logic [MAX_DIGITS-1:0] an_off(input int digits);
    an_off = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) an_off = an_off | (MAX_DIGITS'(1) << i);
    end
  endfunction

  function automatic logic [MAX_DIGITS-1:0] an_mask(input int idx, input int digits);
    an_mask = an_off(digits) & ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/hex7.sv
// Combinational hex nibble to active-low 7-segment decoder.
// Output bit order 6..0 = g..a.
module hex7 (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    unique case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/hex7_scan.sv
// Time-multiplexed scan controller for a common-anode multi-digit display,
// with double-buffered value, leading-zero blanking and ghost blanking.
module hex7_scan
  import hex7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int BLANK  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame,
  output logic                  pend
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] AN_OFF = DIGITS'(an_off(DIGITS));

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] disp_r;
  logic [DIGITS-1:0]   dpd_r;
  logic [4*DIGITS-1:0] pend_v;
  logic [DIGITS-1:0]   pend_dp;

  logic                slot_end;
  logic                boundary;
  logic                blank_phase;
  logic                lz_hit;
  logic [3:0]          nib;
  logic [6:0]          dec_seg;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;
  logic [DIGITS-1:0]   an_nxt;

  assign slot_end    = (cnt == CNT_W'(DIV - 1));
  assign boundary    = slot_end && (idx == IDX_W'(DIGITS - 1));
  assign blank_phase = (cnt < CNT_W'(BLANK));
  assign nib         = disp_r[{idx, 2'b00} +: 4];
  // Digit idx is a leading zero when it and every more-significant nibble are 0.
  assign lz_hit      = lz_en && (idx != '0) && ((disp_r >> {idx, 2'b00}) == '0);

  hex7 u_hex7 (
    .nibble (nib),
    .seg    (dec_seg)
  );

  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (!blank_phase) begin
      dp_nxt = ~dpd_r[idx];
      if (!lz_hit) begin
        an_nxt  = DIGITS'(an_mask(int'(idx), DIGITS));
        seg_nxt = dec_seg;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      idx     <= '0;
      disp_r  <= '0;
      dpd_r   <= '0;
      pend_v  <= '0;
      pend_dp <= '0;
      pend    <= 1'b0;
      frame   <= 1'b0;
      an      <= AN_OFF;
      seg     <= SEG_OFF;
      dp      <= 1'b1;
    end else begin
      cnt   <= slot_end ? '0 : cnt + 1'b1;
      frame <= boundary;
      an    <= an_nxt;
      seg   <= seg_nxt;
      dp    <= dp_nxt;
      if (slot_end) idx <= boundary ? '0 : idx + 1'b1;
      // A load landing on the boundary bypasses the pending buffer.
      if (boundary) begin
        if (ld) begin
          disp_r <= din;
          dpd_r  <= dp_in;
        end else if (pend) begin
          disp_r <= pend_v;
          dpd_r  <= pend_dp;
        end
        pend <= 1'b0;
      end else if (ld) begin
        pend_v  <= din;
        pend_dp <= dp_in;
        pend    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex7_scan.sv
// Directed self-checking bench for hex7_scan with DIGITS=4, DIV=8, BLANK=2.
// Outputs after edge k reflect slot position k-1 (frame of 32 edges).
module tb_hex7_scan;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ld;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;
  logic        pend;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SF = 7'b0001110;

  hex7_scan #(.DIGITS(4), .DIV(8), .BLANK(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ld      (ld),
    .din     (din),
    .dp_in   (dp_in),
    .lz_en   (lz_en),
    .seg     (seg),
    .dp      (dp),
    .an      (an),
    .frame   (frame),
    .pend    (pend)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    edges++;
    #1;
  endtask

  task automatic goto(input int k);
    while (edges < k) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_an,
                         input logic [6:0] e_seg, input logic e_dp);
    chk({tag, ".an"}, 16'(an), 16'(e_an));
    chk({tag, ".seg"}, 16'(seg), 16'(e_seg));
    chk({tag, ".dp"}, 16'(dp), 16'(e_dp));
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    ld = 1'b1; din = v; dp_in = d;
    tick();
    ld = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ld = 1'b0; din = '0; dp_in = '0; lz_en = 1'b0;
    #23;
    chk_out("reset", 4'hF, 7'h7F, 1'b1);
    chk("reset.frame", 16'(frame), 16'd0);
    chk("reset.pend", 16'(pend), 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    edges = 0;

    // Idle scan of value 0
    goto(1);  chk_out("idle.blank0", 4'hF, 7'h7F, 1'b1);
    goto(3);  chk_out("idle.d0", 4'hE, S0, 1'b1);
    goto(11); chk_out("idle.d1", 4'hD, S0, 1'b1);
    goto(19); chk_out("idle.d2", 4'hB, S0, 1'b1);
    goto(27); chk_out("idle.d3", 4'h7, S0, 1'b1);
    goto(31); chk("idle.frame31", 16'(frame), 16'd0);
    goto(32); chk("idle.frame32", 16'(frame), 16'd1);
    goto(33); chk("idle.frame33", 16'(frame), 16'd0);
    chk_out("idle.blank33", 4'hF, 7'h7F, 1'b1);
    goto(64); chk("idle.frame64", 16'(frame), 16'd1);

    // Mid-frame load held pending until the boundary
    goto(70); load(16'h1A2F, 4'b0100);
    chk("ld1.pend", 16'(pend), 16'd1);
    goto(95); chk("ld1.pend95", 16'(pend), 16'd1);
    chk_out("ld1.old", 4'h7, S0, 1'b1);
    goto(96); chk("ld1.frame", 16'(frame), 16'd1);
    chk("ld1.pend96", 16'(pend), 16'd0);
    goto(99);  chk_out("ld1.d0", 4'hE, SF, 1'b1);
    goto(107); chk_out("ld1.d1", 4'hD, S2, 1'b1);
    goto(113); chk_out("ld1.d2blank", 4'hF, 7'h7F, 1'b1);
    goto(115); chk_out("ld1.d2", 4'hB, SA, 1'b0);
    goto(123); chk_out("ld1.d3", 4'h7, S1, 1'b1);

    // Leading-zero suppression of 0050
    lz_en = 1'b1;
    goto(130); load(16'h0050, 4'b0000);
    goto(163); chk_out("lz50.d0", 4'hE, S0, 1'b1);
    goto(171); chk_out("lz50.d1", 4'hD, S5, 1'b1);
    goto(179); chk_out("lz50.d2", 4'hF, 7'h7F, 1'b1);
    goto(187); chk_out("lz50.d3", 4'hF, 7'h7F, 1'b1);

    // Value 0 with dp on digit 1: digit suppressed but dp still driven
    goto(195); load(16'h0000, 4'b0010);
    goto(227); chk_out("lz0.d0", 4'hE, S0, 1'b1);
    goto(233); chk_out("lz0.d1blank", 4'hF, 7'h7F, 1'b1);
    goto(235); chk_out("lz0.d1", 4'hF, 7'h7F, 1'b0);
    goto(243); chk_out("lz0.d2", 4'hF, 7'h7F, 1'b1);
    lz_en = 1'b0;

    // Two loads before a boundary: last one wins
    goto(245); load(16'h1111, 4'b0000);
    goto(248); load(16'h2222, 4'b0000);
    goto(259); chk_out("last.d0", 4'hE, S2, 1'b1);
    goto(267); chk_out("last.d1", 4'hD, S2, 1'b1);
    goto(283); chk_out("last.d3", 4'h7, S2, 1'b1);

    // Load on the exact boundary overrides a pending value
    goto(280); load(16'h3333, 4'b0000);
    chk("bnd.pendpre", 16'(pend), 16'd1);
    goto(287); load(16'hBEEF, 4'b0000);
    chk("bnd.frame", 16'(frame), 16'd1);
    chk("bnd.pend", 16'(pend), 16'd0);
    goto(291); chk_out("bnd.d0", 4'hE, SF, 1'b1);
    goto(299); chk_out("bnd.d1", 4'hD, SE, 1'b1);

    // Asynchronous reset in the middle of a drive phase with a pending load
    goto(296); load(16'h5555, 4'b0000);
    goto(300); chk("rst.pendpre", 16'(pend), 16'd1);
    chk_out("rst.pre", 4'hD, SE, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk_out("rst.async", 4'hF, 7'h7F, 1'b1);
    chk("rst.pend", 16'(pend), 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    edges = 0;
    goto(2); chk_out("rst.blank", 4'hF, 7'h7F, 1'b1);
    goto(3); chk_out("rst.d0", 4'hE, S0, 1'b1);
    goto(11); chk_out("rst.d1", 4'hD, S0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
